mprj_checkpoint_monitor: RTL and testbench

- Parametrised checkpoint-sequence monitor; successor to the fixed two-code (start/done) wait on the management-SoC checkpoint bus.
- Watches a WIDTH-bit checkpoint bus, normally mprj_io[31:16], driven by firmware.
- Filters out glitches, then tracks an ordered list of NUM_STAGES milestone codes, with a per-stage watchdog and an abort code.
- Synthesisable, so it can be used in RTL and GL benches or as an on-chip self-test observer in the user project area.

---
 rtl/mprj_chkmon_pkg.sv | 30 +++
 rtl/mprj_chkmon_filter.sv | 43 ++++
 rtl/mprj_checkpoint_monitor.sv | 192 +++++++++++++++++++
 tb/tb_mprj_checkpoint_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mprj_chkmon_pkg.sv
// Shared types and helpers for the checkpoint-sequence monitor.
package mprj_chkmon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_TRACK   = 3'd2,
        ST_PASS    = 3'd3,
        ST_FAIL    = 3'd4,
        ST_TIMEOUT = 3'd5
    } chk_state_e;

    localparam int STAGE_IDX_W = 4;
    localparam int CODE_MAX_W  = 32;
    localparam int MAX_STAGES  = 16;
    localparam int FLAT_MAX_W  = CODE_MAX_W * MAX_STAGES;

    // Returns code[idx] from a flattened list of width-bit codes (stage 0 in the LSBs);
    // callers truncate the result to their own code width.
    function automatic logic [CODE_MAX_W-1:0] code_at(
        input logic [FLAT_MAX_W-1:0]  codes,
        input int                     width,
        input logic [STAGE_IDX_W-1:0] idx
    );
        int base;
        base = int'(idx) * width;
        return codes[base +: CODE_MAX_W];
    endfunction

endpackage

// File: rtl/mprj_chkmon_filter.sv
// Glitch filter: emits one event per distinct value that stays stable for STABLE_CYCLES samples.
module mprj_chkmon_filter #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_bus,
    output logic             o_event,
    output logic [WIDTH-1:0] o_value
);

    localparam int HOLD_W = $clog2(STABLE_CYCLES + 2);
    localparam logic [HOLD_W-1:0] HOLD_HIT = HOLD_W'(STABLE_CYCLES);

    logic [WIDTH-1:0]  r_sample;
    logic [HOLD_W-1:0] r_hold;

    // Sample register and hold counter; the counter parks one past the hit value so the event fires once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sample <= '0;
            r_hold   <= '0;
        end else if (i_clear) begin
            r_sample <= '0;
            r_hold   <= '0;
        end else begin
            r_sample <= i_bus;
            if (i_bus != r_sample) begin
                r_hold <= HOLD_W'(1);
            end else if (r_hold <= HOLD_HIT) begin
                r_hold <= r_hold + HOLD_W'(1);
            end else begin
                r_hold <= r_hold;
            end
        end
    end

    assign o_event = (r_hold == HOLD_HIT);
    assign o_value = r_sample;

endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint-sequence monitor: filtered bus events walk an ordered list of stage codes under a watchdog.
// Optional macro MPRJ_CHKMON_STRICT_ORDER_EN turns out-of-order stage codes into a FAIL.
module mprj_checkpoint_monitor
    import mprj_chkmon_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int NUM_STAGES     = 4,
    parameter int STABLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic                        clock,
    input  logic                        RSTB,
    input  logic                        enable,
    input  logic [WIDTH-1:0]            checkbits,
    input  logic [NUM_STAGES*WIDTH-1:0] stage_codes,
    input  logic [WIDTH-1:0]            abort_code,
    output logic                        started,
    output logic [STAGE_IDX_W-1:0]      stage_idx,
    output logic                        pass,
    output logic                        fail,
    output logic                        timeout,
    output logic [WIDTH-1:0]            fail_code,
    output logic [CNT_W-1:0]            cycle_count
);

    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]        WD_LIMIT   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STAGE_IDX_W-1:0] LAST_STAGE = STAGE_IDX_W'(NUM_STAGES - 1);

    chk_state_e             r_state, w_state_nxt;
    logic [STAGE_IDX_W-1:0] r_stage_idx, w_stage_idx_nxt;
    logic                   r_started, w_started_nxt;
    logic                   r_pass, w_pass_nxt;
    logic                   r_fail, w_fail_nxt;
    logic                   r_timeout, w_timeout_nxt;
    logic [WIDTH-1:0]       r_fail_code, w_fail_code_nxt;
    logic [CNT_W-1:0]       r_cycle_count, w_cycle_count_nxt;
    logic [WD_W-1:0]        r_wdog, w_wdog_nxt;

    logic                   w_filt_clear;
    logic                   w_event;
    logic [WIDTH-1:0]       w_value;
    logic [FLAT_MAX_W-1:0]  w_codes_ext;
    logic [WIDTH-1:0]       w_code0;
    logic [WIDTH-1:0]       w_code_exp;
    logic                   w_strict_hit;

    assign w_filt_clear = ~enable;
    assign w_codes_ext  = FLAT_MAX_W'(stage_codes);
    assign w_code0      = WIDTH'(code_at(w_codes_ext, WIDTH, STAGE_IDX_W'(0)));
    assign w_code_exp   = WIDTH'(code_at(w_codes_ext, WIDTH, r_stage_idx));

    mprj_chkmon_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .i_clk   (clock),
        .i_rst_n (RSTB),
        .i_clear (w_filt_clear),
        .i_bus   (checkbits),
        .o_event (w_event),
        .o_value (w_value)
    );

`ifdef MPRJ_CHKMON_STRICT_ORDER_EN
    // Out-of-order hit: any listed code other than the expected one or the one just matched.
    always_comb begin
        w_strict_hit = 1'b0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if ((w_value == WIDTH'(code_at(w_codes_ext, WIDTH, STAGE_IDX_W'(j)))) &&
                (j != int'(r_stage_idx)) && (j != int'(r_stage_idx) - 1)) begin
                w_strict_hit = 1'b1;
            end else begin
                w_strict_hit = w_strict_hit;
            end
        end
    end
`else
    assign w_strict_hit = 1'b0;
`endif

    // Next-state and next-output logic; abort outranks a stage match, an advance outranks expiry.
    always_comb begin
        w_state_nxt       = r_state;
        w_stage_idx_nxt   = r_stage_idx;
        w_started_nxt     = r_started;
        w_pass_nxt        = r_pass;
        w_fail_nxt        = r_fail;
        w_timeout_nxt     = r_timeout;
        w_fail_code_nxt   = r_fail_code;
        w_cycle_count_nxt = r_cycle_count;
        w_wdog_nxt        = r_wdog;
        if (!enable) begin
            w_state_nxt     = ST_IDLE;
            w_stage_idx_nxt = '0;
            w_wdog_nxt      = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt       = ST_ARMED;
                    w_stage_idx_nxt   = '0;
                    w_started_nxt     = 1'b0;
                    w_pass_nxt        = 1'b0;
                    w_fail_nxt        = 1'b0;
                    w_timeout_nxt     = 1'b0;
                    w_fail_code_nxt   = '0;
                    w_cycle_count_nxt = '0;
                    w_wdog_nxt        = '0;
                end
                ST_ARMED: begin
                    if (w_event && (w_value == w_code0)) begin
                        w_state_nxt     = ST_TRACK;
                        w_started_nxt   = 1'b1;
                        w_stage_idx_nxt = STAGE_IDX_W'(1);
                        w_wdog_nxt      = '0;
                    end else begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_TRACK: begin
                    w_cycle_count_nxt = (r_cycle_count == {CNT_W{1'b1}}) ?
                                        r_cycle_count : r_cycle_count + CNT_W'(1);
                    if (w_event && (w_value == abort_code)) begin
                        w_state_nxt     = ST_FAIL;
                        w_fail_nxt      = 1'b1;
                        w_fail_code_nxt = abort_code;
                    end else if (w_event && (w_value == w_code_exp)) begin
                        w_stage_idx_nxt = r_stage_idx + STAGE_IDX_W'(1);
                        w_wdog_nxt      = '0;
                        if (r_stage_idx == LAST_STAGE) begin
                            w_state_nxt = ST_PASS;
                            w_pass_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_TRACK;
                        end
                    end else if (w_event && w_strict_hit) begin
                        w_state_nxt     = ST_FAIL;
                        w_fail_nxt      = 1'b1;
                        w_fail_code_nxt = w_value;
                    end else if (r_wdog == WD_LIMIT) begin
                        w_state_nxt   = ST_TIMEOUT;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_wdog_nxt = r_wdog + WD_W'(1);
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt     = ST_IDLE;
                    w_stage_idx_nxt = '0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            r_state       <= ST_IDLE;
            r_stage_idx   <= '0;
            r_started     <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_timeout     <= 1'b0;
            r_fail_code   <= '0;
            r_cycle_count <= '0;
            r_wdog        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_stage_idx   <= w_stage_idx_nxt;
            r_started     <= w_started_nxt;
            r_pass        <= w_pass_nxt;
            r_fail        <= w_fail_nxt;
            r_timeout     <= w_timeout_nxt;
            r_fail_code   <= w_fail_code_nxt;
            r_cycle_count <= w_cycle_count_nxt;
            r_wdog        <= w_wdog_nxt;
        end
    end

    assign started     = r_started;
    assign stage_idx   = r_stage_idx;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign fail_code   = r_fail_code;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// Directed bench: event-history model compared every cycle, plus hand-computed spot checks.
module tb_mprj_checkpoint_monitor;

    localparam int W  = 16;
    localparam int NS = 4;
    localparam int ST = 2;
    localparam int TO = 50;
    localparam int CW = 32;

    logic          clock;
    logic          RSTB;
    logic          enable;
    logic [W-1:0]  checkbits;
    logic [NS*W-1:0] stage_codes;
    logic [W-1:0]  abort_code;
    logic          started;
    logic [3:0]    stage_idx;
    logic          pass;
    logic          fail;
    logic          timeout;
    logic [W-1:0]  fail_code;
    logic [CW-1:0] cycle_count;

    int n_checks = 0;
    int n_errors = 0;

    mprj_checkpoint_monitor #(
        .WIDTH(W), .NUM_STAGES(NS), .STABLE_CYCLES(ST), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clock(clock), .RSTB(RSTB), .enable(enable), .checkbits(checkbits),
        .stage_codes(stage_codes), .abort_code(abort_code), .started(started),
        .stage_idx(stage_idx), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_code(fail_code), .cycle_count(cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- model ----------------
    localparam int M_IDLE = 0, M_ARMED = 1, M_TRACK = 2, M_DONE = 3;
    logic [W-1:0] hist[$];
    int      m_mode = M_IDLE;
    int      m_stage = 0;
    bit      m_started = 0, m_pass = 0, m_fail = 0, m_to = 0;
    logic [W-1:0] m_fcode = '0;
    longint  m_count = 0;
    longint  edge_n = 0, t_start = 0, t_prog = 0;

    function automatic logic [W-1:0] code_of(input int j);
        return stage_codes[j*W +: W];
    endfunction

    // A value is reported when its last ST samples agree and the sample before them differs or predates a clear.
    function automatic bit filt_event();
        int sz;
        sz = hist.size();
        if (sz < ST) return 1'b0;
        for (int k = sz - ST; k < sz; k++)
            if (hist[k] != hist[sz-1]) return 1'b0;
        if (sz == ST) return 1'b1;
        return hist[sz-ST-1] != hist[sz-1];
    endfunction

    function automatic bit out_of_order(input logic [W-1:0] v, input int stg);
        for (int j = 0; j < NS; j++)
            if (code_of(j) == v && j != stg && j != stg - 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_mode = M_IDLE; m_stage = 0; m_started = 0; m_pass = 0; m_fail = 0; m_to = 0;
        m_fcode = '0; m_count = 0;
    endtask

    task automatic model_step();
        bit ev;
        logic [W-1:0] v;
        edge_n++;
        ev = filt_event();
        v  = (hist.size() > 0) ? hist[hist.size()-1] : '0;
        if (!enable) begin
            m_mode = M_IDLE; m_stage = 0; hist.delete();
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_mode = M_ARMED; m_started = 0; m_pass = 0; m_fail = 0; m_to = 0;
                    m_fcode = '0; m_count = 0; m_stage = 0;
                end
                M_ARMED: if (ev && v == code_of(0)) begin
                    m_mode = M_TRACK; m_started = 1; m_stage = 1; t_start = edge_n; t_prog = edge_n;
                end
                M_TRACK: begin
                    m_count = edge_n - t_start;
                    if (ev && v == abort_code) begin
                        m_fail = 1; m_fcode = v; m_mode = M_DONE;
                    end else if (ev && v == code_of(m_stage)) begin
                        m_stage++; t_prog = edge_n;
                        if (m_stage == NS) begin m_pass = 1; m_mode = M_DONE; end
                    end
`ifdef MPRJ_CHKMON_STRICT_ORDER_EN
                    else if (ev && out_of_order(v, m_stage)) begin
                        m_fail = 1; m_fcode = v; m_mode = M_DONE;
                    end
`endif
                    else if (edge_n - t_prog == TO) begin
                        m_to = 1; m_mode = M_DONE;
                    end
                end
                default: ;
            endcase
            hist.push_back(checkbits);
            if (hist.size() > ST + 1) void'(hist.pop_front());
        end
    endtask

    initial forever begin
        @(posedge clock or negedge RSTB);
        if (!RSTB) model_reset();
        else model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clock);
        check("m.started", 32'(started), 32'(m_started));
        check("m.stage_idx", 32'(stage_idx), 32'(m_stage));
        check("m.pass", 32'(pass), 32'(m_pass));
        check("m.fail", 32'(fail), 32'(m_fail));
        check("m.timeout", 32'(timeout), 32'(m_to));
        check("m.fail_code", 32'(fail_code), 32'(m_fcode));
        check("m.cycle_count", cycle_count, m_count[31:0]);
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic hold(input logic [W-1:0] v, input int n);
        checkbits = v;
        step(n);
    endtask

    task automatic arm();
        enable = 1'b0; checkbits = '0;
        step(2);
        enable = 1'b1;
        step(3);
    endtask

    initial begin
        RSTB = 1'b0; enable = 1'b0; checkbits = '0;
        stage_codes = {16'hDEAD, 16'h2222, 16'h1111, 16'hFEED};
        abort_code  = 16'hBAD0;
        step(2);
        check("rst.all", {started, stage_idx, pass, fail, timeout, fail_code, cycle_count[8:0]}, 32'h0);
        RSTB = 1'b1;

        // full in-order sequence
        arm();
        hold(16'hFEED, 10); check("seq.stage1", 32'(stage_idx), 32'd1);
        check("seq.started", 32'(started), 32'd1);
        hold(16'h1111, 10); check("seq.stage2", 32'(stage_idx), 32'd2);
        hold(16'h2222, 10); check("seq.stage3", 32'(stage_idx), 32'd3);
        hold(16'hDEAD, 10); check("seq.stage4", 32'(stage_idx), 32'd4);
        check("seq.pass", {pass, fail, timeout}, 32'b100);
        check("seq.count", cycle_count, 32'd30);

        // glitch rejection and start latency
        arm();
        hold(16'hFEED, 1);
        hold(16'h0000, 5); check("glitch.started", 32'(started), 32'd0);
        hold(16'hFEED, 2); check("lat.edge2", 32'(started), 32'd0);
        hold(16'h0000, 1); check("lat.edge3", 32'(started), 32'd1);

        // watchdog expiry
        arm();
        hold(16'hFEED, 4);
        hold(16'h1111, 60);
        check("to.flags", {pass, timeout}, 32'b01);
        check("to.stage", 32'(stage_idx), 32'd2);

        // advance on the expiry cycle wins
        arm();
        hold(16'hFEED, 4);
        hold(16'h1111, 50);
        hold(16'h2222, 5);
        check("to.edge.timeout", 32'(timeout), 32'd0);
        check("to.edge.stage", 32'(stage_idx), 32'd3);

        // abort
        arm();
        hold(16'hFEED, 10);
        hold(16'h1111, 10);
        hold(16'hBAD0, 10);
        hold(16'h2222, 10);
        check("abort.fail", 32'(fail), 32'd1);
        check("abort.code", 32'(fail_code), 32'hBAD0);
        check("abort.stage", 32'(stage_idx), 32'd2);

        // out-of-order code
        arm();
        hold(16'hFEED, 10);
        hold(16'hDEAD, 10);
`ifdef MPRJ_CHKMON_STRICT_ORDER_EN
        check("strict.fail", 32'(fail), 32'd1);
        check("strict.code", 32'(fail_code), 32'hDEAD);
`else
        check("loose.ignored", {fail, stage_idx}, {27'd0, 1'b0, 4'd1});
        hold(16'h1111, 10);
        hold(16'h2222, 10);
        hold(16'hDEAD, 10);
        check("loose.pass", 32'(pass), 32'd1);
`endif

        // enable drop mid-TRACK, then re-arm
        arm();
        hold(16'hFEED, 5);
        hold(16'h1111, 5);
        enable = 1'b0;
        step(1);
        check("drop.stage", 32'(stage_idx), 32'd0);
        check("drop.started_kept", 32'(started), 32'd1);
        enable = 1'b1;
        step(1);
        check("rearm.cleared", {started, cycle_count[15:0]}, 32'd0);

        // asynchronous reset mid-TRACK
        hold(16'hFEED, 6);
        check("pre_rst.started", 32'(started), 32'd1);
        #2 RSTB = 1'b0;
        #1 check("async_rst.all", {started, stage_idx, pass, fail, timeout, fail_code, cycle_count[8:0]}, 32'h0);
        step(2);
        RSTB = 1'b1;
        step(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
